regfile: RTL and testbench

REGFILE -- requirements
Module: regfile

---
 rtl/regfile.sv | 72 +++++++
 tb/tb_regfile.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/regfile.sv
// Three-port register file: fifteen stored registers R0..R14, two combinational
// read ports, one synchronous write port; address 15 reads the external r15 input.
module regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we3,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic [ADDR_W-1:0] wa3,
    input  logic [DATA_W-1:0] wd3,
    input  logic [DATA_W-1:0] r15,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);

    localparam int NREGS = 15;

    logic [DATA_W-1:0] mem_q [0:NREGS-1];
    logic [DATA_W-1:0] mem_d [0:NREGS-1];

    // Address 15 is never stored; it always returns the supplied PC+8 value.
    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] pc_val,
        input logic [DATA_W-1:0] regs [0:NREGS-1]
    );
        logic [DATA_W-1:0] val;
        val = pc_val;
        for (int i = 0; i < NREGS; i++) begin
            if (addr == i[ADDR_W-1:0]) begin
                val = regs[i];
            end else begin
                val = val;
            end
        end
        return val;
    endfunction

    // Next-state of the storage array: a single write, suppressed for address 15.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            if (we3 && (wa3 == i[ADDR_W-1:0])) begin
                mem_d[i] = wd3;
            end else begin
                mem_d[i] = mem_q[i];
            end
        end
    end

    // Storage registers; asynchronous clear blocks any write while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Read ports are purely combinational: no bypass, so a same-cycle write shows after the edge.
    always_comb begin
        rd1 = read_port(ra1, r15, mem_q);
        rd2 = read_port(ra2, r15, mem_q);
    end

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile: hand-computed vectors checked with
// immediate assertions in one linear stimulus sequence.
module tb_regfile;

    logic        clk;
    logic        rst_n;
    logic        we3;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic [3:0]  wa3;
    logic [31:0] wd3;
    logic [31:0] r15;
    logic [31:0] rd1;
    logic [31:0] rd2;

    int vectors;
    int miscompares;
    logic [31:0] exp_regs [0:14];

    regfile #(.DATA_W(32), .ADDR_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .we3   (we3),
        .ra1   (ra1),
        .ra2   (ra2),
        .wa3   (wa3),
        .wd3   (wd3),
        .r15   (r15),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        we3 = 1'b1;
        wa3 = a;
        wd3 = d;
        tick();
        we3 = 1'b0;
    endtask

    // Reads every stored register on both ports against exp_regs.
    task automatic chk_all(input string tag);
        for (int i = 0; i < 15; i++) begin
            ra1 = i[3:0];
            ra2 = 4'(14 - i);
            #1;
            chk({tag, "_rd1"}, rd1, exp_regs[i]);
            chk({tag, "_rd2"}, rd2, exp_regs[14 - i]);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n = 1'b1;
        we3   = 1'b0;
        ra1   = 4'd0;
        ra2   = 4'd15;
        wa3   = 4'd0;
        wd3   = 32'd0;
        r15   = 32'h0000_1234;
        for (int i = 0; i < 15; i++) exp_regs[i] = 32'd0;

        #1 rst_n = 1'b0;
        #2;
        chk("rst_rd1_r0", rd1, 32'd0);
        chk("rst_rd2_r15", rd2, 32'h0000_1234);
        tick();
        tick();
        #2 rst_n = 1'b1;
        chk_all("after_reset");

        // Two writes then dual read
        wr(4'd3, 32'd7);
        wr(4'd6, 32'd9);
        ra1 = 4'd3; ra2 = 4'd6; #1;
        chk("w3_rd1", rd1, 32'd7);
        chk("w6_rd2", rd2, 32'd9);

        wr(4'd5, 32'd8);
        wr(4'd0, 32'd15);
        ra1 = 4'd5; ra2 = 4'd0; #1;
        chk("w5_rd1", rd1, 32'd8);
        chk("w0_rd2", rd2, 32'd15);
        ra1 = 4'd3; ra2 = 4'd6; #1;
        chk("keep3_rd1", rd1, 32'd7);
        chk("keep6_rd2", rd2, 32'd9);
        exp_regs[0] = 32'd15; exp_regs[3] = 32'd7;
        exp_regs[5] = 32'd8;  exp_regs[6] = 32'd9;

        // r15 is combinational passthrough
        r15 = 32'd16; ra1 = 4'd15; #1;
        chk("r15_16", rd1, 32'd16);
        r15 = 32'd20; #1;
        chk("r15_20", rd1, 32'd20);

        // Write to 15 ignored; we3=0 ignored
        wr(4'd15, 32'hDEAD_BEEF);
        we3 = 1'b0; wa3 = 4'd4; wd3 = 32'h0000_0055;
        tick();
        ra1 = 4'd15; #1;
        chk("r15_after_wa15", rd1, 32'd20);
        ra2 = 4'd4; #1;
        chk("r4_unchanged", rd2, 32'd0);
        chk_all("no_write");

        // Same register on both ports, no bypass
        wr(4'd7, 32'hA5A5_A5A5);
        exp_regs[7] = 32'hA5A5_A5A5;
        ra1 = 4'd7; ra2 = 4'd7;
        we3 = 1'b1; wa3 = 4'd7; wd3 = 32'h0000_0001; #1;
        chk("r7_old_rd1", rd1, 32'hA5A5_A5A5);
        chk("r7_old_rd2", rd2, 32'hA5A5_A5A5);
        tick();
        we3 = 1'b0;
        chk("r7_new_rd1", rd1, 32'h0000_0001);
        chk("r7_new_rd2", rd2, 32'h0000_0001);

        // Mid-operation reset between edges
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 15; i++) exp_regs[i] = 32'd0;
        chk_all("mid_reset");
        we3 = 1'b1; wa3 = 4'd2; wd3 = 32'h0000_00FF;
        tick();
        we3 = 1'b0;
        ra1 = 4'd2; ra2 = 4'd15; #1;
        chk("r2_blocked", rd1, 32'd0);
        chk("rst_r15", rd2, 32'd20);

        // First edge after release may write
        #2 rst_n = 1'b1;
        wr(4'd2, 32'h0000_0033);
        ra1 = 4'd2; #1;
        chk("first_write", rd1, 32'h0000_0033);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
